// File: rtl/multi_pulse_width_detector_if.sv
// multi_pulse_width_detector_if: channel inputs, window settings and detector results
//   a, polarity : per-channel input level and active polarity
//   min_w, max_w: accepted pulse-width window in cycles
//   clr         : clears hit_cnt
//   detected, too_long, hit_cnt: per-channel strobes and aggregate hit count
interface multi_pulse_width_detector_if #(
   parameter int N     = 4,
   parameter int MAX_W = 8,
   parameter int CW    = $clog2(MAX_W + 2),
   parameter int HW    = 16
);
   logic [N-1:0]  a;
   logic [N-1:0]  polarity;
   logic [CW-1:0] min_w;
   logic [CW-1:0] max_w;
   logic          clr;
   logic [N-1:0]  detected;
   logic [N-1:0]  too_long;
   logic [HW-1:0] hit_cnt;
   modport master (output a, polarity, min_w, max_w, clr, input detected, too_long, hit_cnt);
   modport slave  (input a, polarity, min_w, max_w, clr, output detected, too_long, hit_cnt);
endinterface

// File: rtl/multi_pulse_width_detector.sv
// multi_pulse_width_detector: N-channel programmable-width pulse detector with saturating hit counter
//   clk   : clock, all state on posedge
//   rst_n : asynchronous active-low reset
//   bus   : slave side; a, polarity, min_w, max_w, clr in; detected, too_long, hit_cnt out
module multi_pulse_width_detector #(
   parameter int N     = 4,
   parameter int MAX_W = 8,
   parameter int CW    = $clog2(MAX_W + 2),
   parameter int HW    = 16
) (
   input logic clk,
   input logic rst_n,
   multi_pulse_width_detector_if.slave bus
);
   localparam logic [CW-1:0] SAT = CW'(MAX_W + 1);
   logic [N-1:0]  x, x_r, x_r_d, pol_r, fired, fired_d, det_d, tl_d, det_r, tl_r;
   logic [CW-1:0] cnt   [N];
   logic [CW-1:0] cnt_d [N];
   logic [CW-1:0] lo;
   logic [HW:0]   sum;
   logic [HW-1:0] hit_d, hit_r;
   assign bus.detected = det_r;
   assign bus.too_long = tl_r;
   assign bus.hit_cnt  = hit_r;
   always_comb begin
      lo  = (bus.min_w == '0) ? CW'(1) : bus.min_w;
      sum = {1'b0, hit_r};
      for (int i = 0; i < N; i++) begin
         x[i]       = bus.a[i] ^ bus.polarity[i];
         x_r_d[i]   = x[i];
         fired_d[i] = fired[i];
         cnt_d[i]   = cnt[i];
         det_d[i]   = 1'b0;
         tl_d[i]    = 1'b0;
         if (bus.polarity[i] != pol_r[i]) begin
            // park the channel as a saturated active run: it cannot strobe or detect,
            // and the first idle sample under the new polarity ends it silently
            x_r_d[i]   = 1'b1;
            cnt_d[i]   = SAT;
            fired_d[i] = 1'b1;
         end else if (x[i] && !x_r[i]) begin
            cnt_d[i]   = CW'(1);
            fired_d[i] = 1'b0;
         end else if (x[i]) begin
            cnt_d[i]   = (cnt[i] == SAT) ? SAT : cnt[i] + 1'b1;
            // fired guards against a second strobe if max_w moves mid-pulse
            tl_d[i]    = (cnt[i] == bus.max_w) && !fired[i];
            fired_d[i] = fired[i] | tl_d[i];
         end else begin
            det_d[i] = x_r[i] && (cnt[i] >= lo) && (cnt[i] <= bus.max_w);
            cnt_d[i] = '0;
         end
         sum = sum + (HW + 1)'(det_d[i]);
      end
      hit_d = bus.clr ? '0 : sum[HW] ? '1 : sum[HW-1:0];
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         x_r   <= '0;
         pol_r <= '0;
         fired <= '0;
         cnt   <= '{default: '0};
         det_r <= '0;
         tl_r  <= '0;
         hit_r <= '0;
      end else begin
         x_r   <= x_r_d;
         pol_r <= bus.polarity;
         fired <= fired_d;
         cnt   <= cnt_d;
         det_r <= det_d;
         tl_r  <= tl_d;
         hit_r <= hit_d;
      end
endmodule

// File: tb/tb_multi_pulse_width_detector.sv
// tb_multi_pulse_width_detector: directed table and sequence checks for multi_pulse_width_detector
module tb_multi_pulse_width_detector;
   logic clk = 1'b0;
   logic rst_n;
   int n_cmp = 0;
   int n_err = 0;
   typedef struct {
      logic [3:0]  a;
      logic [3:0]  mn;
      logic [3:0]  mx;
      logic        clr;
      logic [3:0]  det;
      logic [3:0]  tl;
      logic [15:0] hit;
   } vec_t;
   vec_t tbl[$];
   multi_pulse_width_detector_if #(.N(4), .MAX_W(8), .HW(16)) bus ();
   multi_pulse_width_detector #(.N(4), .MAX_W(8), .HW(16)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
   always #5 clk = ~clk;
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
      end
   endtask
   function automatic void add(input logic [3:0] a, mn, mx, input logic clr,
                               input logic [3:0] det, tl, input logic [15:0] hit);
      vec_t v;
      v.a = a; v.mn = mn; v.mx = mx; v.clr = clr; v.det = det; v.tl = tl; v.hit = hit;
      tbl.push_back(v);
   endfunction
   initial begin
      logic [9:0] pat;
      rst_n        = 1'b1;
      bus.a        = '0;
      bus.polarity = '0;
      bus.min_w    = 4'd1;
      bus.max_w    = 4'd1;
      bus.clr      = 1'b0;
      #1 rst_n = 1'b0;
      #2;
      chk("reset_det", 32'(bus.detected), 0);
      chk("reset_tl", 32'(bus.too_long), 0);
      chk("reset_hit", 32'(bus.hit_cnt), 0);
      #19 rst_n = 1'b1;
      // single-cycle pulse, window [1,1]
      add(0, 1, 1, 0, 0, 0, 0);
      add(1, 1, 1, 0, 0, 0, 0);
      add(0, 1, 1, 0, 1, 0, 1);
      add(0, 1, 1, 0, 0, 0, 1);
      // ch1 pulses of 1, 3, 5 cycles, window [2,4]
      add(2, 2, 4, 0, 0, 0, 1);
      add(0, 2, 4, 0, 0, 0, 1);
      for (int k = 0; k < 3; k++) add(2, 2, 4, 0, 0, 0, 1);
      add(0, 2, 4, 0, 2, 0, 2);
      for (int k = 0; k < 5; k++) add(2, 2, 4, 0, 0, (k == 4) ? 4'd2 : 4'd0, 2);
      add(0, 2, 4, 0, 0, 0, 2);
      // min_w > max_w: no detect, too_long still fires
      for (int k = 0; k < 2; k++) add(1, 3, 2, 0, 0, 0, 2);
      add(0, 3, 2, 0, 0, 0, 2);
      for (int k = 0; k < 3; k++) add(1, 3, 2, 0, 0, (k == 2) ? 4'd1 : 4'd0, 2);
      add(0, 3, 2, 0, 0, 0, 2);
      // min_w = 0 behaves as 1
      add(4, 0, 1, 0, 0, 0, 2);
      add(0, 0, 1, 0, 4, 0, 3);
      // 10-cycle pulse saturates, max_w = MAX_W
      for (int k = 0; k < 10; k++) add(8, 1, 8, 0, 0, (k == 8) ? 4'd8 : 4'd0, 3);
      add(0, 1, 8, 0, 0, 0, 3);
      // exactly MAX_W cycles is accepted
      for (int k = 0; k < 8; k++) add(8, 1, 8, 0, 0, 0, 3);
      add(0, 1, 8, 0, 8, 0, 4);
      // ch0 and ch3 end together, then again with clr
      add(9, 1, 1, 0, 0, 0, 4);
      add(0, 1, 1, 0, 9, 0, 6);
      add(9, 1, 1, 0, 0, 0, 6);
      add(0, 1, 1, 1, 9, 0, 0);
      add(0, 1, 1, 0, 0, 0, 0);
      foreach (tbl[r]) begin
         bus.a     = tbl[r].a;
         bus.min_w = tbl[r].mn;
         bus.max_w = tbl[r].mx;
         bus.clr   = tbl[r].clr;
         tick();
         chk($sformatf("row%0d_det", r), 32'(bus.detected), 32'(tbl[r].det));
         chk($sformatf("row%0d_tl", r), 32'(bus.too_long), 32'(tbl[r].tl));
         chk($sformatf("row%0d_hit", r), 32'(bus.hit_cnt), 32'(tbl[r].hit));
      end
      bus.clr = 1'b0;
      // ch2 low pulse under polarity 1, window [1,2]
      bus.min_w = 4'd1;
      bus.max_w = 4'd2;
      bus.polarity = 4'b0100;
      bus.a = 4'b0100;
      tick();
      chk("pol2_change_det", 32'(bus.detected), 0);
      chk("pol2_change_tl", 32'(bus.too_long), 0);
      tick();
      tick();
      bus.a = 4'b0000;
      tick();
      tick();
      bus.a = 4'b0100;
      tick();
      chk("pol2_low_det", 32'(bus.detected), 32'h4);
      chk("pol2_low_hit", 32'(bus.hit_cnt), 1);
      // same waveform with polarity 0 never detects
      bus.polarity = 4'b0000;
      pat = 10'b0011100111;
      for (int k = 0; k < 10; k++) begin
         bus.a = {1'b0, pat[k], 2'b00};
         tick();
         chk($sformatf("pol0_nodet%0d", k), 32'(bus.detected), 0);
      end
      bus.a = 4'b0000;
      tick();
      // toggle polarity[1] mid-pulse, window [1,4]
      bus.max_w = 4'd4;
      bus.a = 4'b0010;
      tick();
      tick();
      bus.polarity = 4'b0010;
      tick();
      chk("toggle_det", 32'(bus.detected), 0);
      chk("toggle_tl", 32'(bus.too_long), 0);
      tick();
      chk("discard_det", 32'(bus.detected), 0);
      chk("discard_tl", 32'(bus.too_long), 0);
      tick();
      bus.a = 4'b0000;
      tick();
      tick();
      bus.a = 4'b0010;
      tick();
      chk("after_toggle_det", 32'(bus.detected), 32'h2);
      chk("after_toggle_hit", 32'(bus.hit_cnt), 2);
      bus.polarity = 4'b0000;
      bus.a = 4'b0000;
      repeat (3) tick();
      // async reset while a strobe is showing and a pulse is in progress
      bus.max_w = 4'd1;
      bus.a = 4'b0001;
      tick();
      bus.a = 4'b0000;
      tick();
      chk("pre_reset_det", 32'(bus.detected), 1);
      #3 rst_n = 1'b0;
      bus.a = 4'b0001;
      #1;
      chk("async_reset_det", 32'(bus.detected), 0);
      chk("async_reset_hit", 32'(bus.hit_cnt), 0);
      #2 rst_n = 1'b1;
      tick();
      chk("post_reset_start", 32'(bus.detected), 0);
      bus.a = 4'b0000;
      tick();
      chk("post_reset_det", 32'(bus.detected), 1);
      chk("post_reset_hit", 32'(bus.hit_cnt), 1);
      // hit_cnt saturation
      bus.clr = 1'b1;
      tick();
      bus.clr = 1'b0;
      chk("clr_hit", 32'(bus.hit_cnt), 0);
      repeat (16383) begin
         bus.a = 4'b1111;
         tick();
         bus.a = 4'b0000;
         tick();
      end
      chk("near_sat_hit", 32'(bus.hit_cnt), 65532);
      bus.a = 4'b0111;
      tick();
      bus.a = 4'b0000;
      tick();
      chk("at_sat_hit", 32'(bus.hit_cnt), 65535);
      bus.a = 4'b1111;
      tick();
      bus.a = 4'b0000;
      tick();
      chk("sat_det", 32'(bus.detected), 32'hf);
      chk("sat_hold_hit", 32'(bus.hit_cnt), 65535);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
